// File: rtl/sdram_bridge_arbiter.sv
// Round-robin arbiter that sequences single-beat transactions from two requesters
// onto the SDRAM external bridge, aborting any transaction whose acknowledge never arrives.
module sdram_bridge_arbiter #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [1:0]        a_be,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [1:0]        b_be,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] bridge_address,
    output logic [1:0]        bridge_byte_enable,
    output logic              bridge_read,
    output logic              bridge_write,
    output logic [DATA_W-1:0] bridge_write_data,
    input  logic              bridge_acknowledge,
    input  logic [DATA_W-1:0] bridge_read_data,
    output logic              busy
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RECOVER = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;   // 0 = port A, 1 = port B
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [1:0]        be_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              read_nxt, write_nxt, busy_nxt;
    logic              a_ack_nxt, a_err_nxt, b_ack_nxt, b_err_nxt;
    logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt;
    logic              pick_b, sel_we;

    // B wins only when A is silent or A was served last.
    assign pick_b = b_req && (!a_req || !last_grant);
    assign sel_we = pick_b ? b_we : a_we;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        timer_nxt      = timer;
        addr_nxt       = bridge_address;
        be_nxt         = bridge_byte_enable;
        wdata_nxt      = bridge_write_data;
        read_nxt       = bridge_read;
        write_nxt      = bridge_write;
        a_ack_nxt      = 1'b0;
        a_err_nxt      = 1'b0;
        a_rdata_nxt    = a_rdata;
        b_ack_nxt      = 1'b0;
        b_err_nxt      = 1'b0;
        b_rdata_nxt    = b_rdata;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nxt      = BUSY;
                    last_grant_nxt = pick_b;
                    timer_nxt      = '0;
                    addr_nxt       = pick_b ? b_addr  : a_addr;
                    be_nxt         = pick_b ? b_be    : a_be;
                    wdata_nxt      = pick_b ? b_wdata : a_wdata;
                    read_nxt       = !sel_we;
                    write_nxt      = sel_we;
                end
            end
            BUSY: begin
                // An acknowledge on the terminal timer count still completes normally.
                if (bridge_acknowledge || timer == TMR_LAST) begin
                    state_nxt = RECOVER;
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    timer_nxt = '0;
                    if (last_grant) begin
                        b_ack_nxt = 1'b1;
                        b_err_nxt = !bridge_acknowledge;
                        if (!bridge_acknowledge)
                            b_rdata_nxt = '0;
                        else if (bridge_read)
                            b_rdata_nxt = bridge_read_data;
                    end else begin
                        a_ack_nxt = 1'b1;
                        a_err_nxt = !bridge_acknowledge;
                        if (!bridge_acknowledge)
                            a_rdata_nxt = '0;
                        else if (bridge_read)
                            a_rdata_nxt = bridge_read_data;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            timer              <= '0;
            bridge_address     <= '0;
            bridge_byte_enable <= '0;
            bridge_write_data  <= '0;
            bridge_read        <= 1'b0;
            bridge_write       <= 1'b0;
            a_ack              <= 1'b0;
            a_err              <= 1'b0;
            a_rdata            <= '0;
            b_ack              <= 1'b0;
            b_err              <= 1'b0;
            b_rdata            <= '0;
            busy               <= 1'b0;
        end else begin
            state              <= state_nxt;
            last_grant         <= last_grant_nxt;
            timer              <= timer_nxt;
            bridge_address     <= addr_nxt;
            bridge_byte_enable <= be_nxt;
            bridge_write_data  <= wdata_nxt;
            bridge_read        <= read_nxt;
            bridge_write       <= write_nxt;
            a_ack              <= a_ack_nxt;
            a_err              <= a_err_nxt;
            a_rdata            <= a_rdata_nxt;
            b_ack              <= b_ack_nxt;
            b_err              <= b_err_nxt;
            b_rdata            <= b_rdata_nxt;
            busy               <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_sdram_bridge_arbiter.sv
// Bench for sdram_bridge_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_sdram_bridge_arbiter;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam int T      = 8;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [1:0]        a_be = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [1:0]        b_be = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              a_ack, a_err, b_ack, b_err;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] bridge_address;
    logic [1:0]        bridge_byte_enable;
    logic              bridge_read, bridge_write;
    logic [DATA_W-1:0] bridge_write_data;
    logic              bridge_acknowledge = 1'b0;
    logic [DATA_W-1:0] bridge_read_data = '0;
    logic              busy;

    int checks = 0;
    int errors = 0;

    sdram_bridge_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET(RESET),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
        .bridge_read(bridge_read), .bridge_write(bridge_write),
        .bridge_write_data(bridge_write_data), .bridge_acknowledge(bridge_acknowledge),
        .bridge_read_data(bridge_read_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bridge responder: mode 0 never acks, 1 acks after a fixed delay, 2 acks at random.
    int                ack_mode = 1;
    int                ack_delay = 2;
    int                cmd_age = 0;
    logic [DATA_W-1:0] rsp_data = '0;

    always @(negedge CLK) begin
        if (bridge_read === 1'b1 || bridge_write === 1'b1) cmd_age++;
        else cmd_age = 0;
        case (ack_mode)
            0:       bridge_acknowledge = 1'b0;
            1:       bridge_acknowledge = (cmd_age == ack_delay + 1);
            default: bridge_acknowledge = (cmd_age > 0) && ($urandom_range(0, 3) == 0);
        endcase
        bridge_read_data = (ack_mode == 2) ? DATA_W'($urandom) : rsp_data;
    end

    // Reference model: tracks the in-flight transaction by how long its command has been
    // on the bridge and the first cycle at which a new request may be accepted.
    int                cyc = 0, free_at = 0, m_cnt = 0;
    bit                model_valid = 0, m_on = 0, m_port = 0, m_last = 1, m_we = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [1:0]        e_be = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_a_rdata = '0, e_b_rdata = '0;
    logic              e_rd = 0, e_wr = 0, e_a_ack = 0, e_a_err = 0, e_b_ack = 0, e_b_err = 0, e_busy = 0;

    always @(posedge CLK) begin
        cyc++;
        e_a_ack = 0; e_a_err = 0; e_b_ack = 0; e_b_err = 0;
        if (RESET) begin
            model_valid = 1; m_on = 0; m_last = 1; free_at = cyc;
            e_addr = '0; e_be = '0; e_wdata = '0; e_rd = 0; e_wr = 0;
            e_a_rdata = '0; e_b_rdata = '0;
        end else if (m_on) begin
            if (bridge_acknowledge || m_cnt == T) begin
                m_on = 0; free_at = cyc + 1; e_rd = 0; e_wr = 0;
                if (m_port) begin
                    e_b_ack = 1; e_b_err = !bridge_acknowledge;
                    if (!bridge_acknowledge) e_b_rdata = '0;
                    else if (!m_we) e_b_rdata = bridge_read_data;
                end else begin
                    e_a_ack = 1; e_a_err = !bridge_acknowledge;
                    if (!bridge_acknowledge) e_a_rdata = '0;
                    else if (!m_we) e_a_rdata = bridge_read_data;
                end
            end else begin
                m_cnt++;
            end
        end else if (cyc - 1 >= free_at && (a_req || b_req)) begin
            m_port = b_req && (!a_req || !m_last);
            m_last = m_port;
            m_we   = m_port ? b_we : a_we;
            e_addr = m_port ? b_addr : a_addr;
            e_be   = m_port ? b_be : a_be;
            e_wdata = m_port ? b_wdata : a_wdata;
            e_rd = !m_we; e_wr = m_we;
            m_on = 1; m_cnt = 1;
        end
        e_busy = m_on || (cyc < free_at);
        #1;
        if (model_valid) begin
            chk("m_addr", bridge_address, e_addr);
            chk("m_be", bridge_byte_enable, e_be);
            chk("m_wdata", bridge_write_data, e_wdata);
            chk("m_read", bridge_read, e_rd);
            chk("m_write", bridge_write, e_wr);
            chk("m_a_ack", a_ack, e_a_ack);
            chk("m_a_err", a_err, e_a_err);
            chk("m_a_rdata", a_rdata, e_a_rdata);
            chk("m_b_ack", b_ack, e_b_ack);
            chk("m_b_err", b_err, e_b_err);
            chk("m_b_rdata", b_rdata, e_b_rdata);
            chk("m_busy", busy, e_busy);
        end
    end

    int                r_wr, r_rd, r_bad, r_acks;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    task automatic run_txn(input int max_cyc, input bit port,
                           input logic [ADDR_W-1:0] xa, input logic [DATA_W-1:0] xd);
        bit done;
        done = 0;
        r_wr = 0; r_rd = 0; r_bad = 0; r_acks = 0; r_err = 1'bx; r_rdata = 'x;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(posedge CLK); #1;
            if (bridge_write) r_wr++;
            if (bridge_read) r_rd++;
            if ((bridge_read || bridge_write) &&
                (bridge_address !== xa || (bridge_write && bridge_write_data !== xd))) r_bad++;
            if (a_ack || b_ack) r_acks++;
            if (port ? b_ack : a_ack) begin
                done = 1;
                r_err = port ? b_err : a_err;
                r_rdata = port ? b_rdata : a_rdata;
                chk("busy_during_ack", busy, 1);
            end
        end
        chk("txn_completed", done, 1);
        @(negedge CLK);
        if (port) b_req = 0; else a_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int code;
        bit dbl, prev_a, prev_b;

        repeat (3) @(negedge CLK);
        chk("reset_busy", busy, 0);
        chk("reset_cmd", {bridge_read, bridge_write}, 0);
        chk("reset_addr", bridge_address, 0);
        chk("reset_acks", {a_ack, b_ack}, 0);
        RESET = 0;
        @(negedge CLK);

        // Write on A, acknowledged two cycles after the command appears.
        a_we = 1; a_addr = 25; a_be = 2'b11; a_wdata = 16'hAFFA; a_req = 1;
        ack_mode = 1; ack_delay = 2;
        run_txn(20, 0, 25, 16'hAFFA);
        chk("t1_write_cycles", r_wr, 3);
        chk("t1_read_cycles", r_rd, 0);
        chk("t1_fields", r_bad, 0);
        chk("t1_ack_count", r_acks, 1);
        chk("t1_err", r_err, 0);
        @(posedge CLK); #1;
        chk("t1_busy_dropped", busy, 0);
        chk("t1_ack_single", a_ack, 0);
        @(negedge CLK);

        // Read on B returning 1234.
        b_we = 0; b_addr = 25; b_be = 2'b11; b_req = 1; rsp_data = 16'h1234; ack_delay = 0;
        run_txn(20, 1, 25, 16'h0);
        chk("t2_write_cycles", r_wr, 0);
        chk("t2_read_cycles", r_rd, 1);
        chk("t2_rdata", r_rdata, 16'h1234);
        chk("t2_err", r_err, 0);
        @(negedge CLK);

        // Both ports held high for four transactions.
        a_we = 0; a_addr = 1; a_be = 2'b11; b_we = 0; b_addr = 2; b_be = 2'b01;
        a_req = 1; b_req = 1; rsp_data = 16'h5A5A; ack_delay = 1;
        dbl = 0; prev_a = 0; prev_b = 0;
        for (int k = 0; k < 80 && order.size() < 4; k++) begin
            @(posedge CLK); #1;
            if (a_ack && b_ack) dbl = 1;
            if ((a_ack && prev_a) || (b_ack && prev_b)) dbl = 1;
            if (a_ack) order.push_back(0);
            if (b_ack) order.push_back(1);
            prev_a = a_ack; prev_b = b_ack;
        end
        @(negedge CLK);
        a_req = 0; b_req = 0;
        code = (order.size() == 4) ? (order[0] * 8 + order[1] * 4 + order[2] * 2 + order[3]) : -1;
        chk("t3_grant_order", code, 4'b0101);
        chk("t3_single_ack", dbl, 0);
        @(negedge CLK);

        // A read that is never acknowledged, then a normal B write.
        ack_mode = 0; a_we = 0; a_addr = 7; a_req = 1;
        run_txn(30, 0, 7, 16'h0);
        chk("t4_read_cycles", r_rd, T);
        chk("t4_err", r_err, 1);
        chk("t4_rdata", r_rdata, 0);
        ack_mode = 1; ack_delay = 2;
        b_we = 1; b_addr = 9; b_be = 2'b01; b_wdata = 16'h0F0F; b_req = 1;
        run_txn(20, 1, 9, 16'h0F0F);
        chk("t4_b_write_cycles", r_wr, 3);
        chk("t4_b_err", r_err, 0);
        @(negedge CLK);

        // Reset in the third BUSY cycle of an A write.
        ack_mode = 0; a_we = 1; a_addr = 11; a_wdata = 16'h5555; a_be = 2'b10; a_req = 1;
        repeat (3) @(negedge CLK);
        chk("t5_cmd_before_reset", bridge_write, 1);
        RESET = 1; a_req = 0;
        @(posedge CLK); #1;
        chk("t5_cmd_dropped", {bridge_read, bridge_write}, 0);
        chk("t5_no_ack", {a_ack, a_err, b_ack, b_err}, 0);
        chk("t5_busy", busy, 0);
        chk("t5_outputs_zero", {bridge_address, bridge_byte_enable, bridge_write_data, a_rdata, b_rdata}, 0);
        @(negedge CLK);
        RESET = 0;
        ack_mode = 1; ack_delay = 0; rsp_data = 16'hC3C3;
        a_we = 0; a_addr = 3; b_we = 0; b_addr = 4; a_req = 1; b_req = 1;
        run_txn(20, 0, 3, 16'h0);
        chk("t5_first_grant_a", r_acks, 1);
        chk("t5_a_rdata", r_rdata, 16'hC3C3);
        run_txn(20, 1, 4, 16'h0);
        chk("t5_b_err", r_err, 0);
        @(negedge CLK);

        // Acknowledge on the last cycle before the timeout.
        ack_delay = T - 1; rsp_data = 16'hBEEF; a_we = 0; a_addr = 13; a_req = 1;
        run_txn(30, 0, 13, 16'h0);
        chk("t6_read_cycles", r_rd, T);
        chk("t6_err", r_err, 0);
        chk("t6_rdata", r_rdata, 16'hBEEF);
        @(negedge CLK);

        // Random traffic; requesters hold fields until ack and sometimes chain.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (a_req) begin
                if (a_ack) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a_we = 1'($urandom); a_addr = ADDR_W'($urandom);
                        a_be = 2'($urandom); a_wdata = DATA_W'($urandom);
                    end else a_req = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                a_req = 1; a_we = 1'($urandom); a_addr = ADDR_W'($urandom);
                a_be = 2'($urandom); a_wdata = DATA_W'($urandom);
            end
            if (b_req) begin
                if (b_ack) begin
                    if ($urandom_range(0, 1) == 1) begin
                        b_we = 1'($urandom); b_addr = ADDR_W'($urandom);
                        b_be = 2'($urandom); b_wdata = DATA_W'($urandom);
                    end else b_req = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                b_req = 1; b_we = 1'($urandom); b_addr = ADDR_W'($urandom);
                b_be = 2'($urandom); b_wdata = DATA_W'($urandom);
            end
        end
        @(posedge CLK); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_bridge_arbiter.md
Name: sdram_bridge_arbiter

Overview:
- Two-requester arbiter and sequencer for the SDRAM external bridge port of the Nios system (address, byte enable, read, write, write data, acknowledge, read data).
- Lets the UART loader FSM (port A) and a second fabric master, such as a display refresh engine (port B), share the bridge without changing the Qsys system.
- Issues one single-beat transaction at a time, using round-robin priority.
- Guards each transaction with a timeout so a missing acknowledge cannot hang the fabric.

Parameters:
- ADDR_W, 23, bridge word-address width.
- DATA_W, 16, bridge data width.
- TIMEOUT_CYCLES, 1024, BUSY cycles without acknowledge before abort; minimum 2.

Ports:
- CLK  in  1  system clock (same CLK that feeds niosqs).
- RESET  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_be  in  2  port A byte enables, active-high.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- a_err  out  1  port A timeout flag; valid with a_ack.
- a_rdata  out  DATA_W  port A read data; valid with a_ack.
- b_req, b_we, b_addr, b_be, b_wdata, b_ack, b_err, b_rdata: identical set for port B.
- bridge_address  out  ADDR_W  to sdram_bridge_ext_address.
- bridge_byte_enable  out  2  to sdram_bridge_ext_byte_enable.
- bridge_read  out  1  read command.
- bridge_write  out  1  write command.
- bridge_write_data  out  DATA_W  write data.
- bridge_acknowledge  in  1  from sdram_bridge_ext_acknowledge.
- bridge_read_data  in  DATA_W  from sdram_bridge_ext_read_data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state = IDLE, last_grant = B (so A wins the first tie), timer = 0.
- FSM states:
  - IDLE: sample a_req and b_req.
    - If neither is high, stay in IDLE.
    - If exactly one is high, grant it.
    - If both are high, grant the port that is not last_grant.
    - On grant: latch the winner's we, addr, be and wdata into the bridge output registers; assert bridge_read (we=0) or bridge_write (we=1); set last_grant to the winner; go to BUSY.
  - BUSY: hold the command and all bridge outputs stable; the timer increments each cycle.
    - If bridge_acknowledge=1: drop read and write; pulse the winner's ack; capture bridge_read_data into the winner's rdata (reads only; writes leave rdata unchanged); set err=0; clear the timer; go to RECOVER.
    - If there is no acknowledge and timer = TIMEOUT_CYCLES-1: drop the command; pulse ack with err=1 and rdata=0; clear the timer; go to RECOVER.
    - If acknowledge and timeout occur in the same cycle, acknowledge wins (err=0).
  - RECOVER: the command stays low for one cycle; ack and err are cleared; go to IDLE.
- Latency:
  - A request first seen in IDLE at cycle c puts the command on the bridge in cycle c+1.
  - An acknowledge in cycle t gives the requester ack in cycle t+1 and the next IDLE sample in cycle t+2.
  - The best case is 3 cycles per transaction.
- Requester rules:
  - Fields must be stable from req rise until ack.
  - A requester may keep req high after ack to chain a new transaction; new fields must be valid by the cycle after ack.
  - req is ignored outside IDLE.
  - A loser's req stays pending and is granted next (starvation-free).
- bridge_read and bridge_write are never high together. Only one ack pulses at a time, and it lasts exactly one cycle.
- bridge_address, bridge_byte_enable and bridge_write_data keep their last values when idle. There are no don't-care toggles.
- RESET mid-transaction: at that edge, drop the command, return to IDLE and clear the timer. No ack is issued for the aborted transaction.
- Timer width is clog2(TIMEOUT_CYCLES). The timer cannot wrap because it clears at terminal count.

Test Plan:
1. After reset, raise a_req with we=1, addr=25, be=2'b11, wdata=16'hAFFA; bridge acks 2 cycles after the command -> bridge_write high for exactly 3 cycles with address 25 and data AFFA; a_ack pulses once with a_err=0; busy drops 2 cycles after acknowledge.
2. Read on port B at addr=25; bridge returns 16'h1234 with acknowledge -> b_rdata=1234 during the b_ack cycle; bridge_write stays 0 throughout.
3. a_req and b_req rise together and both are held high for 4 transactions -> grant order is A, B, A, B; each ack is a single cycle; no overlap between transactions.
4. TIMEOUT_CYCLES=8 and the bridge never acknowledges a port A read -> the command is dropped after exactly 8 BUSY cycles; a_ack=1, a_err=1, a_rdata=0; a subsequent b_req is served normally.
5. Assert RESET in the 3rd BUSY cycle of a port A write -> the command is low in the next cycle; no a_ack; all outputs are 0; the first grant after reset goes to A.
6. Acknowledge arrives in the same cycle the timer reaches TIMEOUT_CYCLES-1 -> ack is issued with err=0 and rdata is captured.
